tt_sweep_ctrl: RTL and testbench

//  Sequencer that exhaustively characterises one combinational gate netlist (N_IN inputs, 1 output).

---
 rtl/tt_sweep_pkg.sv | 22 ++
 rtl/tt_settle_timer.sv | 29 ++
 rtl/tt_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
// Holds the sequencer state encoding and legal parameter ranges.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned N_IN_MIN   = 1;
  localparam int unsigned N_IN_MAX   = 6;
  localparam int unsigned SETTLE_MIN = 0;
  localparam int unsigned SETTLE_MAX = 15;

  // Truth-table width for an n-input function.
  function automatic int unsigned tt_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-delay counter: loads SETTLE, counts down while enabled,
// and flags zero combinationally so the FSM can leave SETTLE on time.
module tt_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every input vector of a gate netlist,
// packs the sampled outputs into a truth table and compares it to an expected one.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [tt_w(N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [tt_w(N_IN)-1:0]   tt,
  output logic                    tt_valid,
  output logic                    match
);

  localparam int unsigned TT_W  = tt_w(N_IN);
  localparam int unsigned IDX_W = N_IN + 1;

  state_e            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [N_IN-1:0]   dut_in_n;
  logic [TT_W-1:0]   tt_n, exp_q, exp_n;
  logic              tt_valid_n, match_n, busy_n, done_n;
  logic              timer_load, settle_zero_c;

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .dec    (state == ST_SETTLE),
    .zero_c (settle_zero_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      dut_in   <= '0;
      tt       <= '0;
      exp_q    <= '0;
      tt_valid <= 1'b0;
      match    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      dut_in   <= dut_in_n;
      tt       <= tt_n;
      exp_q    <= exp_n;
      tt_valid <= tt_valid_n;
      match    <= match_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-register values; abort beats start and sampling.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    dut_in_n   = dut_in;
    tt_n       = tt;
    exp_n      = exp_q;
    tt_valid_n = tt_valid;
    match_n    = match;
    timer_load = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          idx_n      = '0;
          dut_in_n   = '0;
          timer_load = 1'b1;
          exp_n      = exp_tt;
          tt_n       = '0;
          tt_valid_n = 1'b0;
          match_n    = 1'b0;
          state_n    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          dut_in_n = '0;
          state_n  = ST_IDLE;
        end else if (settle_zero_c) begin
          state_n = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          dut_in_n = '0;
          state_n  = ST_IDLE;
        end else begin
          tt_n = {tt[TT_W-2:0], dut_out};
          if (idx == IDX_W'(TT_W - 1)) begin
            state_n = ST_DONE;
          end else begin
            idx_n      = idx + IDX_W'(1);
            dut_in_n   = N_IN'(idx + IDX_W'(1));
            timer_load = 1'b1;
            state_n    = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        tt_valid_n = 1'b1;
        match_n    = (tt == exp_q);
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: golden/mismatch/constant sweeps, reset, abort
// and start-while-busy, with expected tables queued at start and checked at done.
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        start, abort;
  logic [15:0] exp_tt;
  logic [3:0]  dut_in;
  logic        dut_out, busy, done, tt_valid, match;
  logic [15:0] tt;

  logic        start0, abort0;
  logic [15:0] exp0;
  logic [3:0]  dut_in0;
  logic        dut_out0, busy0, done0, tt_valid0, match0;
  logic [15:0] tt0;
  logic        c_const;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] tt;
    logic        m;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference gate function: a=_0 (MSB of the vector) .. d=_3 (LSB).
  function automatic logic golden(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return ~(~c & (a ^ b)) & (d ^ (~a & b));
  endfunction

  function automatic logic [15:0] model_prefix(input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[14:0], golden(4'(i))};
    return r;
  endfunction

  assign dut_out  = golden(dut_in);
  assign dut_out0 = c_const;

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .tt(tt), .tt_valid(tt_valid), .match(match)
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .exp_tt(exp0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .tt(tt0), .tt_valid(tt_valid0), .match(match0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full sweep on the main (s0=0) or SETTLE=0 (s0=1) instance.
  task automatic run_sweep(input bit s0, input logic [15:0] e, input int lat,
                           input int alt_cyc, input logic [15:0] alt_e);
    exp_t x;
    int   cyc;
    x.tt = s0 ? {16{c_const}} : model_prefix(16);
    x.m  = (x.tt == e);
    sb.push_back(x);
    if (s0) begin exp0 = e; start0 = 1'b1; end
    else    begin exp_tt = e; start = 1'b1; end
    tick();
    start = 1'b0; start0 = 1'b0;
    cyc = 1;
    chk("busy_cycle1", s0 ? busy0 : busy, 1);
    while (!(s0 ? done0 : done) && cyc < 150) begin
      if (!s0 && cyc == alt_cyc) begin start = 1'b1; exp_tt = alt_e; end
      if (!s0 && cyc == 13) chk("tt_vec0_to_2", tt[2:0], model_prefix(3));
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("done_latency", cyc, lat);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      x = sb.pop_front();
      chk("tt_at_done", s0 ? tt0 : tt, x.tt);
      tick();
      chk("tt_valid", s0 ? tt_valid0 : tt_valid, 1);
      chk("match", s0 ? match0 : match, x.m);
      chk("busy_after", s0 ? busy0 : busy, 0);
      chk("done_pulse", s0 ? done0 : done, 0);
    end
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; exp_tt = '0;
    start0 = 1'b0; abort0 = 1'b0; exp0 = '0; c_const = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tt", tt, 0);
    chk("rst_flags", {tt_valid, match}, 0);
    chk("rst_dut_in", dut_in, 0);

    // Reset in the middle of a sweep
    exp_tt = 16'h5215; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin tick(); cyc++; end
    chk("pre_rst_tt", tt, model_prefix(4));
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_tt", tt, 0);
    chk("midrst_flags", {tt_valid, match}, 0);
    chk("midrst_dut_in", dut_in, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Golden sweep
    run_sweep(1'b0, 16'h5215, 65, 0, 16'h0000);
    // Start while busy ignored, then back-to-back mismatch sweep
    run_sweep(1'b0, 16'h5215, 65, 10, 16'h5214);
    run_sweep(1'b0, 16'h5214, 65, 0, 16'h0000);

    // Abort mid-sweep
    exp_tt = 16'h5215; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 30) begin tick(); cyc++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_tt_valid", tt_valid, 0);
    chk("abort_tt_partial", tt, model_prefix(7));
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", saw_done, 0);

    // Abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick(); tick();
    chk("abort_start_idle", busy, 0);
    chk("abort_start_tt", tt, model_prefix(7));

    // Constant DUT with SETTLE=0
    c_const = 1'b1;
    run_sweep(1'b1, 16'hFFFF, 33, 0, 16'h0000);
    c_const = 1'b0;
    run_sweep(1'b1, 16'hFFFF, 33, 0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
